// File: rtl/gated_clk_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gated_clk_sched_pkg
// Purpose  : Shared FSM encoding, reset divisor and channel-index width helper.
// Revision : 1.0
// ============================================================================
package gated_clk_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam int DIV_RST_DEFAULT = 100;

  // Channel-select width; a single channel still gets a 1-bit selector.
  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gated_clk_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : gated_clk_sched_if
// Purpose  : Divisor-update handshake between a configuration master and the
//            gated-clock scheduler.
// Revision : 1.0
// ============================================================================
interface gated_clk_sched_if
  import gated_clk_sched_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int CNTW = 10
);

  localparam int c_chw = ch_width(NCH);

  logic             cfg_valid;
  logic [c_chw-1:0] cfg_ch;
  logic [CNTW-1:0]  cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div,
    output cfg_ready, cfg_err
  );

endinterface
`default_nettype wire

// File: rtl/gated_clk_chan.sv
`default_nettype none
// ============================================================================
// Module   : gated_clk_chan
// Purpose  : One divider channel: counter, active/pending divisor, freeze, ce.
// Revision : 1.0
// ============================================================================
module gated_clk_chan
  import gated_clk_sched_pkg::*;
#(
  parameter int CNTW    = 10,
  parameter int DIV_RST = DIV_RST_DEFAULT
) (
  input  logic            clk_in,
  input  logic            rstn,
  input  logic            i_run,
  input  logic            i_stop,
  input  logic            i_to_idle,
  input  logic            i_wr,
  input  logic [CNTW-1:0] i_wr_div,
  output logic            o_frozen,
  output logic            o_pending,
  output logic            o_ce
);

  localparam logic [CNTW-1:0] c_one     = CNTW'(1);
  localparam logic [CNTW-1:0] c_div_rst = CNTW'(DIV_RST);

  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] r_div;
  logic [CNTW-1:0] r_pdiv;
  logic            r_pend;
  logic            r_ce;
  logic            w_last;
  logic            w_live;

  // Divisor is never zero, so div-1 cannot underflow.
  assign w_last    = (r_cnt == (r_div - c_one));
  // While stopping, a channel sitting at div-1 has finished its period.
  assign w_live    = i_run | (i_stop & ~w_last);
  assign o_frozen  = i_stop & w_last;
  assign o_pending = r_pend;
  assign o_ce      = r_ce;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_div  <= c_div_rst;
      r_pdiv <= '0;
      r_pend <= 1'b0;
      r_ce   <= 1'b0;
    end else begin
      r_ce <= w_live & (r_cnt == '0);
      if (i_to_idle) begin
        r_cnt <= '0;
        if (r_pend) begin
          r_div  <= r_pdiv;
          r_pend <= 1'b0;
        end else if (i_wr) begin
          r_div <= i_wr_div;
        end
      end else if (i_run) begin
        if (w_last) begin
          r_cnt <= '0;
          if (r_pend) begin
            r_div  <= r_pdiv;
            r_pend <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + c_one;
        end
        // Placed after the wrap so a same-cycle write stays pending.
        if (i_wr) begin
          r_pdiv <= i_wr_div;
          r_pend <= 1'b1;
        end
      end else if (i_stop) begin
        if (!w_last) begin
          r_cnt <= r_cnt + c_one;
        end
        if (i_wr) begin
          r_pdiv <= i_wr_div;
          r_pend <= 1'b1;
        end
      end else begin
        r_cnt <= '0;
        if (i_wr) begin
          r_div <= i_wr_div;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gated_clk_sched.sv
`default_nettype none
// ============================================================================
// Module   : gated_clk_sched
// Purpose  : IDLE/RUN/STOP scheduler producing per-channel BUFGCE enables with
//            period-preserving stop and glitch-free divisor updates.
// Revision : 1.0
// ============================================================================
module gated_clk_sched
  import gated_clk_sched_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int CNTW    = 10,
  parameter int DIV_RST = DIV_RST_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rstn,
  input  logic                 run,
  gated_clk_sched_if.slave     cfg,
  output logic [NCH-1:0]       ce,
  output logic                 busy
);

  localparam int c_chw  = ch_width(NCH);
  localparam int c_padw = 2 ** c_chw;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_cfg_err;
  logic [NCH-1:0]    w_frozen;
  logic [NCH-1:0]    w_pending;
  logic [NCH-1:0]    w_ce;
  logic [NCH-1:0]    w_wr_sel;
  logic [c_padw-1:0] w_pending_pad;
  logic              w_in_range;
  logic              w_accept;
  logic              w_bad;
  logic              w_wr;
  logic              w_run_st;
  logic              w_stop_st;
  logic              w_to_idle;

  assign w_run_st  = (r_state == ST_RUN);
  assign w_stop_st = (r_state == ST_STOP);
  assign w_to_idle = w_stop_st & (&w_frozen);

  // Unused selector codes read as "not pending" so they are always ready.
  assign w_pending_pad = c_padw'(w_pending);
  assign w_in_range    = (32'(cfg.cfg_ch) < NCH);
  assign cfg.cfg_ready = ~w_pending_pad[cfg.cfg_ch];
  assign w_accept      = cfg.cfg_valid & cfg.cfg_ready;
  assign w_bad         = w_accept & ((cfg.cfg_div == '0) | ~w_in_range);
  assign w_wr          = w_accept & ~w_bad;
  assign cfg.cfg_err   = r_cfg_err;

  assign busy = (r_state != ST_IDLE);
  assign ce   = w_ce;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cfg_err <= w_bad;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (run)       w_state_next = ST_RUN;
      ST_RUN:  if (!run)      w_state_next = ST_STOP;
      ST_STOP: if (w_to_idle) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign w_wr_sel[gi] = w_wr & (32'(cfg.cfg_ch) == gi);

    gated_clk_chan #(
      .CNTW    (CNTW),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk_in    (clk_in),
      .rstn      (rstn),
      .i_run     (w_run_st),
      .i_stop    (w_stop_st),
      .i_to_idle (w_to_idle),
      .i_wr      (w_wr_sel[gi]),
      .i_wr_div  (cfg.cfg_div),
      .o_frozen  (w_frozen[gi]),
      .o_pending (w_pending[gi]),
      .o_ce      (w_ce[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_gated_clk_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_gated_clk_sched
// Purpose  : Self-checking bench with a behavioural scheduler model.
// Revision : 1.0
// ============================================================================
module tb_gated_clk_sched;
  import gated_clk_sched_pkg::*;

  // Three channels so that an out-of-range channel index is encodable.
  localparam int NCH     = 3;
  localparam int CNTW    = 10;
  localparam int DIV_RST = 100;
  localparam int CHW     = ch_width(NCH);
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STOP  = 2;

  logic           clk_in = 1'b0;
  logic           rstn   = 1'b0;
  logic           run    = 1'b0;
  logic [NCH-1:0] ce;
  logic           busy;

  gated_clk_sched_if #(.NCH(NCH), .CNTW(CNTW)) cfg_if ();

  gated_clk_sched #(.NCH(NCH), .CNTW(CNTW), .DIV_RST(DIV_RST)) dut (
    .clk_in (clk_in),
    .rstn   (rstn),
    .run    (run),
    .cfg    (cfg_if),
    .ce     (ce),
    .busy   (busy)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int             m_state;
  int             m_cnt  [NCH];
  int             m_div  [NCH];
  int             m_pdiv [NCH];
  bit             m_pv   [NCH];
  bit [NCH-1:0]   m_ce;
  bit             m_err;

  task automatic m_reset();
    m_state = M_IDLE;
    m_ce    = '0;
    m_err   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_div[i] = DIV_RST; m_pdiv[i] = 0; m_pv[i] = 1'b0;
    end
  endtask

  function automatic bit m_ready(input int ch);
    return (ch >= NCH) ? 1'b1 : !m_pv[ch];
  endfunction

  task automatic m_step();
    int ch;
    int dv;
    bit acc, bad, good, any_live, settle;
    bit live [NCH];
    ch       = int'(cfg_if.cfg_ch);
    dv       = int'(cfg_if.cfg_div);
    acc      = cfg_if.cfg_valid && m_ready(ch);
    bad      = acc && (dv == 0 || ch >= NCH);
    good     = acc && !bad;
    any_live = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      live[i]  = (m_state == M_RUN) || (m_state == M_STOP && m_cnt[i] != m_div[i] - 1);
      m_ce[i]  = live[i] && (m_cnt[i] == 0);
      any_live = any_live | live[i];
    end
    settle = (m_state == M_STOP) && !any_live;
    for (int i = 0; i < NCH; i++) begin
      if (m_state == M_IDLE) begin
        m_cnt[i] = 0;
        if (good && ch == i) m_div[i] = dv;
      end else if (settle) begin
        m_cnt[i] = 0;
        if (m_pv[i]) begin m_div[i] = m_pdiv[i]; m_pv[i] = 1'b0; end
        else if (good && ch == i) m_div[i] = dv;
      end else begin
        if (m_state == M_RUN) begin
          m_cnt[i] = (m_cnt[i] + 1) % m_div[i];
          if (m_cnt[i] == 0 && m_pv[i]) begin m_div[i] = m_pdiv[i]; m_pv[i] = 1'b0; end
        end else if (live[i]) begin
          m_cnt[i] = m_cnt[i] + 1;
        end
        if (good && ch == i) begin m_pdiv[i] = dv; m_pv[i] = 1'b1; end
      end
    end
    m_err = bad;
    case (m_state)
      M_IDLE:  if (run)    m_state = M_RUN;
      M_RUN:   if (!run)   m_state = M_STOP;
      default: if (settle) m_state = M_IDLE;
    endcase
  endtask

  always @(posedge clk_in or negedge rstn) begin
    if (!rstn) m_reset();
    else       m_step();
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk_in) begin
    if (rstn) begin
      chk("ce", 32'(ce), 32'(m_ce));
      chk("busy", 32'(busy), 32'(m_state != M_IDLE));
      chk("cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
    end
  end

  always @(negedge clk_in) begin
    #2;
    if (rstn) chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_ready(int'(cfg_if.cfg_ch))));
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic cfg_write(input int ch, input int dv);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = CHW'(ch);
    cfg_if.cfg_div   = CNTW'(dv);
    @(negedge clk_in);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_ce(input int ch, output int n);
    n = 0;
    do begin @(negedge clk_in); n++; end while (ce[ch] !== 1'b1 && n < 300);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk_in); n++; end while (busy !== 1'b0 && n < 300);
    chk("reach idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, c0, c1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    repeat (3) @(negedge clk_in);
    chk("rst ce", 32'(ce), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst cfg_err", 32'(cfg_if.cfg_err), 32'd0);
    chk("rst cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    rstn = 1'b1;
    @(negedge clk_in);

    // Defaults: first enable one cycle after RUN entry, then every 100.
    run = 1'b1;
    wait_ce(0, n);
    chk("A first ce latency", n, 2);
    chk("A all channels", 32'(ce), 32'd7);
    wait_ce(0, n);
    chk("A period", n, 100);
    chk("A all channels 2", 32'(ce), 32'd7);

    // Mid-period update completes the current 8-cycle period first.
    run = 1'b0;
    wait_idle();
    cfg_write(0, 8);
    run = 1'b1;
    wait_ce(0, n);
    chk("B first ce latency", n, 2);
    repeat (3) @(negedge clk_in);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = '0; cfg_if.cfg_div = CNTW'(5);
    #1 chk("B ready before write", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk_in);
    cfg_if.cfg_valid = 1'b0;
    #1 chk("B ready after write", 32'(cfg_if.cfg_ready), 32'd0);
    repeat (2) @(negedge clk_in);
    chk("B ready before wrap", 32'(cfg_if.cfg_ready), 32'd0);
    @(negedge clk_in);
    chk("B ready at wrap", 32'(cfg_if.cfg_ready), 32'd1);
    wait_ce(0, n);
    chk("B old period", n, 1);
    wait_ce(0, n);
    chk("B new period", n, 5);
    wait_ce(0, n);
    chk("B new period 2", n, 5);

    // Stop while ch1 is at count 3: ch1 finishes its period silently.
    run = 1'b0;
    wait_idle();
    cfg_write(0, 4);
    cfg_write(1, 10);
    cfg_write(2, 2);
    run = 1'b1;
    repeat (4) @(negedge clk_in);
    run = 1'b0;
    n = 0; c0 = 0; c1 = 0;
    do begin
      @(negedge clk_in); n++; c0 += int'(ce[0]); c1 += int'(ce[1]);
    end while (busy && n < 50);
    chk("C stop to idle cycles", n, 7);
    chk("C ce1 after drop", c1, 0);
    chk("C ce0 after drop", c0, 1);

    // Rejected updates pulse cfg_err and leave divisors alone.
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0;
    #1 chk("D ready div0", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk_in);
    cfg_if.cfg_valid = 1'b0;
    chk("D err div0", 32'(cfg_if.cfg_err), 32'd1);
    @(negedge clk_in);
    chk("D err one cycle", 32'(cfg_if.cfg_err), 32'd0);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = CHW'(3); cfg_if.cfg_div = CNTW'(7);
    #1 chk("D ready bad ch", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk_in);
    cfg_if.cfg_valid = 1'b0;
    chk("D err bad ch", 32'(cfg_if.cfg_err), 32'd1);
    @(negedge clk_in);
    chk("D err one cycle 2", 32'(cfg_if.cfg_err), 32'd0);
    cfg_if.cfg_ch = '0;
    run = 1'b1;
    wait_ce(0, n);
    chk("D first ce latency", n, 2);
    wait_ce(0, n);
    chk("D div unchanged", n, 4);

    // div=1 keeps ce high; async reset drops it at once.
    run = 1'b0;
    wait_idle();
    cfg_write(0, 1);
    run = 1'b1;
    repeat (2) @(negedge clk_in);
    c0 = 0;
    repeat (10) begin c0 += int'(ce[0]); @(negedge clk_in); end
    chk("E ce held high", c0, 10);
    #3 rstn = 1'b0;
    #1;
    chk("E reset ce", 32'(ce), 32'd0);
    chk("E reset busy", 32'(busy), 32'd0);
    @(negedge clk_in);
    run = 1'b0;
    @(negedge clk_in);
    rstn = 1'b1;

    // Randomized traffic against the model.
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_ch    = CHW'($urandom_range(0, 3));
      cfg_if.cfg_div   = ($urandom_range(0, 15) == 0) ? '0 : CNTW'($urandom_range(1, 12));
      @(negedge clk_in);
    end
    cfg_if.cfg_valid = 1'b0;
    run = 1'b0;
    repeat (4) @(negedge clk_in);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
